// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, stall hold, flush bubble; 1-cycle latency.
// SKID_EN adds a second entry so in_ready no longer depends combinationally on out_ready.
module pipe_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 8,
  parameter bit SKID_EN  = 1'b0,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              in_fire, out_fire;
  logic              main_load_in, main_load_skid, skid_load;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

  assign out_valid = (state_q != EMPTY) & ~stall & ~flush;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign occupancy = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = ~stall & ~flush & (state_q != SKID);
    end else begin : g_bare
      assign in_ready = ~stall & ~flush & (~out_valid | out_ready);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d      = FULL;
          main_load_in = 1'b1;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          main_load_in = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          state_d   = SKID;
          skid_load = 1'b1;
        end
      end
      SKID: begin
        // Skid entry is always younger than main, so it only ever refills main.
        if (out_fire) begin
          state_d        = FULL;
          main_load_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      if (CLR_DATA) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end
    end else begin
      if (main_load_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (main_load_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (skid_load) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid instance (SKID_EN=1, CLR_DATA=1) and a bare instance (SKID_EN=0, CLR_DATA=0)
// with shared stimulus and compares each against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          ir1, ov1, ir0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t         mq0[$], mq1[$];
  logic [DW-1:0] last0, last1;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CLR_DATA(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CLR_DATA(1'b0)) dut_bare (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
    .occupancy(occ0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Expected outputs follow from the queue contents; returns the transfers the model predicts.
  task automatic expect_inst(input int k, input logic ir, input logic ov,
                             input logic [DW-1:0] od, input logic [CW-1:0] oc,
                             input logic [1:0] occ, output logic e_in_fire,
                             output logic e_out_fire);
    beat_t         q[$];
    logic [DW-1:0] last, e_od;
    logic [CW-1:0] e_oc;
    logic          e_ov, e_ir;
    string         nm;
    if (k == 1) begin
      q = mq1; last = last1; nm = "skid";
    end else begin
      q = mq0; last = last0; nm = "bare";
    end
    e_ov = (q.size() > 0) && !stall && !flush;
    if (k == 1) e_ir = !stall && !flush && (q.size() < 2);
    else        e_ir = !stall && !flush && (!e_ov || out_ready);
    e_od = last;
    e_oc = '0;
    if (q.size() > 0) begin
      e_od = q[0].d;
      if (e_ov) e_oc = q[0].c;
    end
    chk({nm, "_in_ready"}, 64'(ir), 64'(e_ir));
    chk({nm, "_out_valid"}, 64'(ov), 64'(e_ov));
    chk({nm, "_out_data"}, 64'(od), 64'(e_od));
    chk({nm, "_out_ctrl"}, 64'(oc), 64'(e_oc));
    chk({nm, "_occupancy"}, 64'(occ), 64'(q.size()));
    e_in_fire  = in_valid && e_ir;
    e_out_fire = e_ov && out_ready;
  endtask

  task automatic update_inst(input int k, input logic inf, input logic outf);
    beat_t         q[$];
    logic [DW-1:0] last;
    if (k == 1) begin
      q = mq1; last = last1;
    end else begin
      q = mq0; last = last0;
    end
    if (flush) begin
      q.delete();
      if (k == 1) last = '0;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back('{c: in_ctrl, d: in_data});
      if (q.size() > 0) last = q[0].d;
    end
    if (k == 1) begin
      mq1 = q; last1 = last;
    end else begin
      mq0 = q; last0 = last;
    end
  endtask

  task automatic step(input logic s, input logic f, input logic iv, input logic orr,
                      input logic [DW-1:0] d, input logic [CW-1:0] c);
    logic if0, of0, if1, of1;
    @(negedge clk);
    stall = s; flush = f; in_valid = iv; out_ready = orr; in_data = d; in_ctrl = c;
    #1;
    expect_inst(0, ir0, ov0, od0, oc0, occ0, if0, of0);
    expect_inst(1, ir1, ov1, od1, oc1, occ1, if1, of1);
    @(posedge clk);
    update_inst(0, if0, of0);
    update_inst(1, if1, of1);
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is visible before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_skid_occupancy", 64'(occ1), 64'd0);
    chk("rst_bare_occupancy", 64'(occ0), 64'd0);
    chk("rst_skid_out_valid", 64'(ov1), 64'd0);
    chk("rst_bare_out_valid", 64'(ov0), 64'd0);
    chk("rst_skid_out_ctrl", 64'(oc1), 64'd0);
    chk("rst_bare_out_ctrl", 64'(oc0), 64'd0);
    chk("rst_skid_out_data", 64'(od1), 64'd0);
    chk("rst_bare_out_data", 64'(od0), 64'd0);
    chk("rst_skid_in_ready", 64'(ir1), 64'd1);
    chk("rst_bare_in_ready", 64'(ir0), 64'd1);
    mq0.delete(); mq1.delete();
    last0 = '0; last1 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    last0 = '0; last1 = '0;
    do_reset();

    // Back-to-back streaming at full throughput.
    step(0, 0, 1, 1, 32'h100, 8'h11);
    step(0, 0, 1, 1, 32'h104, 8'h12);
    step(0, 0, 1, 1, 32'h108, 8'h13);
    step(0, 0, 0, 1, 32'h0, 8'h0);
    step(0, 0, 0, 1, 32'h0, 8'h0);

    // Backpressure: skid instance fills to two, third beat waits.
    step(0, 0, 1, 0, 32'hA, 8'h01);
    step(0, 0, 1, 0, 32'hB, 8'h02);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'hC, 8'h03);
    step(0, 0, 1, 1, 32'hC, 8'h03);
    step(0, 0, 1, 1, 32'hC, 8'h03);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 8'h0);

    // Stall holds a single entry, then it leaves exactly once.
    step(0, 0, 1, 0, 32'h55, 8'h05);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, $urandom, 8'($urandom));
    step(0, 0, 0, 1, 32'h0, 8'h0);
    step(0, 0, 0, 1, 32'h0, 8'h0);

    // Flush (with stall) from a full stage drops everything including the input beat.
    step(0, 0, 1, 0, 32'hDEAD, 8'hFF);
    step(0, 0, 1, 0, 32'hBEEF, 8'hFF);
    step(1, 1, 1, 1, 32'h1234, 8'hAB);
    step(0, 0, 0, 0, 32'h0, 8'h0);
    step(0, 0, 0, 1, 32'h0, 8'h0);

    // Bare stage: in_ready follows out_ready in the same cycle.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1'(i % 2), 32'h200 + 32'(i), 8'(i));

    // Async reset mid-stream with the skid instance holding two entries.
    step(0, 0, 1, 0, 32'h300, 8'h31);
    step(0, 0, 1, 0, 32'h304, 8'h32);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
             $urandom, 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
